// File: rtl/controle_votacao_if.sv
// Vote-round handshake between the game controller (master) and the vote sequencer (slave).
// Carries the start pulse, alive mask, per-voter vote/abstain pulses and the round result.
interface controle_votacao_if #(
    parameter int N_JOGADORES = 5,
    parameter int W_ID        = 3
);
    logic                   iniciar;
    logic [N_JOGADORES-1:0] vivos;
    logic                   voto_valido;
    logic [W_ID-1:0]        voto_alvo;
    logic                   abster;
    logic [W_ID-1:0]        jogador_atual;
    logic                   aguardando_voto;
    logic                   fim_votacao;
    logic [W_ID-1:0]        eliminado;
    logic                   houve_eliminacao;
    logic                   empate;
    logic [3:0]             db_estado;

    modport master (
        output iniciar, vivos, voto_valido, voto_alvo, abster,
        input  jogador_atual, aguardando_voto, fim_votacao, eliminado,
               houve_eliminacao, empate, db_estado
    );

    modport slave (
        input  iniciar, vivos, voto_valido, voto_alvo, abster,
        output jogador_atual, aguardando_voto, fim_votacao, eliminado,
               houve_eliminacao, empate, db_estado
    );
endinterface

// File: rtl/controle_votacao.sv
// Day-phase vote sequencer: walks living players, tallies votes, reports the unique maximum.
// Latency: one vote per clock at most; fim_votacao rises N+2 clocks after the last vote/abstention.
// Backpressure: none; a voter is held in ESPERA until a valid vote or an abstention arrives.
module controle_votacao #(
    parameter int N_JOGADORES = 5,
    parameter int W_ID        = 3,
    parameter int W_CONT      = 3
) (
    input logic               clock,
    input logic               reset,
    controle_votacao_if.slave bus
);
    typedef enum logic [3:0] {
        OCIOSO    = 4'd0,
        BUSCA     = 4'd1,
        ESPERA    = 4'd2,
        APURA     = 4'd3,
        RESULTADO = 4'd4
    } estado_t;

    localparam logic [W_ID:0]   N_LIM = (W_ID+1)'(N_JOGADORES);
    localparam logic [W_ID-1:0] ULT   = W_ID'(N_JOGADORES - 1);

    estado_t                estado_q, estado_d;
    logic [N_JOGADORES-1:0] vivos_q, vivos_d;
    logic [W_CONT-1:0]      cont_q [N_JOGADORES];
    logic [W_CONT-1:0]      cont_d [N_JOGADORES];
    // One extra bit so the pointer can reach N and mark the end of the walk.
    logic [W_ID:0]          ptr_q, ptr_d;
    logic [W_ID-1:0]        idx_q, idx_d;
    logic [W_CONT-1:0]      max_q, max_d;
    logic [W_ID-1:0]        cand_q, cand_d;
    logic                   tie_q, tie_d;
    logic [W_ID-1:0]        elim_q, elim_d;
    logic                   houve_q, houve_d;
    logic                   emp_q, emp_d;

    logic                   alvo_vivo;
    logic                   voto_ok;
    logic [W_CONT-1:0]      cont_atual;

    always_comb begin
        estado_d = estado_q;
        vivos_d  = vivos_q;
        cont_d   = cont_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        max_d    = max_q;
        cand_d   = cand_q;
        tie_d    = tie_q;
        elim_d   = elim_q;
        houve_d  = houve_q;
        emp_d    = emp_q;

        alvo_vivo = 1'b0;
        if ({1'b0, bus.voto_alvo} < N_LIM) begin
            alvo_vivo = vivos_q[bus.voto_alvo];
        end
        voto_ok    = bus.voto_valido && alvo_vivo && ({1'b0, bus.voto_alvo} != ptr_q);
        cont_atual = cont_q[idx_q];

        case (estado_q)
            OCIOSO: begin
                if (bus.iniciar) begin
                    vivos_d = bus.vivos;
                    for (int i = 0; i < N_JOGADORES; i++) begin
                        cont_d[i] = '0;
                    end
                    ptr_d    = '0;
                    elim_d   = '0;
                    houve_d  = 1'b0;
                    emp_d    = 1'b0;
                    estado_d = BUSCA;
                end
            end
            BUSCA: begin
                if (ptr_q == N_LIM) begin
                    idx_d    = '0;
                    max_d    = '0;
                    tie_d    = 1'b0;
                    cand_d   = '0;
                    estado_d = APURA;
                end else if (vivos_q[ptr_q[W_ID-1:0]]) begin
                    estado_d = ESPERA;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ESPERA: begin
                // A valid vote takes priority; an invalid one falls back to a pending abstention.
                if (voto_ok) begin
                    cont_d[bus.voto_alvo] = cont_q[bus.voto_alvo] + 1'b1;
                    ptr_d    = ptr_q + 1'b1;
                    estado_d = BUSCA;
                end else if (bus.abster) begin
                    ptr_d    = ptr_q + 1'b1;
                    estado_d = BUSCA;
                end
            end
            APURA: begin
                if (cont_atual > max_q) begin
                    max_d  = cont_atual;
                    cand_d = idx_q;
                    tie_d  = 1'b0;
                end else if ((cont_atual == max_q) && (max_q != '0)) begin
                    tie_d = 1'b1;
                end
                // Result is latched from the final scan step so it is valid alongside fim_votacao.
                if (idx_q == ULT) begin
                    houve_d  = (max_d != '0) && !tie_d;
                    elim_d   = houve_d ? cand_d : '0;
                    emp_d    = tie_d;
                    estado_d = RESULTADO;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            RESULTADO: begin
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= OCIOSO;
            vivos_q  <= '0;
            for (int i = 0; i < N_JOGADORES; i++) begin
                cont_q[i] <= '0;
            end
            ptr_q    <= '0;
            idx_q    <= '0;
            max_q    <= '0;
            cand_q   <= '0;
            tie_q    <= 1'b0;
            elim_q   <= '0;
            houve_q  <= 1'b0;
            emp_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            vivos_q  <= vivos_d;
            cont_q   <= cont_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            max_q    <= max_d;
            cand_q   <= cand_d;
            tie_q    <= tie_d;
            elim_q   <= elim_d;
            houve_q  <= houve_d;
            emp_q    <= emp_d;
        end
    end

    assign bus.jogador_atual    = ptr_q[W_ID-1:0];
    assign bus.aguardando_voto  = (estado_q == ESPERA);
    assign bus.fim_votacao      = (estado_q == RESULTADO);
    assign bus.eliminado        = elim_q;
    assign bus.houve_eliminacao = houve_q;
    assign bus.empate           = emp_q;
    assign bus.db_estado        = estado_q;
endmodule
